// File: rtl/riscv_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and grant-source encodings.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } gnt_src_e;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_perf_ctr.sv
// Saturating stall-cycle counter; only compiled when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access (data wins, fetch starvation guard).
// Define MEM_ARB_PERF_EN to add the perf_if_wait / perf_dm_wait stall-cycle counters.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_wstrb,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall_fetch,
  output logic                  stall_mem
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_if_wait,
  output logic [31:0]           perf_dm_wait
`endif
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e state_q, state_d;
  gnt_src_e   gnt;

  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                dm_valid_q, dm_valid_d;
  logic                starve_hit;

  assign starve_hit = (starve_q == CNT_MAX);

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

  // Grant selection and next state; data side wins unless fetch has waited STARVE_MAX grants.
  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    unique case (state_q)
      IDLE: begin
        if (dm_req && !(if_req && starve_hit)) begin
          gnt = GNT_DM;
        end else if (if_req) begin
          gnt = GNT_IF;
        end
        if (gnt == GNT_DM) begin
          state_d = DM_BUSY;
        end else if (gnt == GNT_IF) begin
          state_d = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory command latch, read-data capture, valid pulses and starvation counter.
  always_comb begin
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;

    unique case (gnt)
      GNT_IF: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        starve_d    = '0;
      end
      GNT_DM: begin
        mem_req_d   = 1'b1;
        mem_we_d    = dm_we;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
        mem_wstrb_d = dm_we ? dm_wstrb : '0;
        if (!if_req) begin
          starve_d = '0;
        end else if (!starve_hit) begin
          starve_d = starve_q + CNT_W'(1);
        end
      end
      default: begin
        if ((state_q == IDLE) && !if_req) begin
          starve_d = '0;
        end
      end
    endcase

    if (mem_ready && (state_q != IDLE)) begin
      mem_req_d = 1'b0;
      if (state_q == IF_BUSY) begin
        if_rdata_d = mem_rdata;
        if_valid_d = 1'b1;
      end else begin
        dm_valid_d = 1'b1;
        if (!mem_we_q) begin
          dm_rdata_d = mem_rdata;
        end
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;

  assign stall_fetch = if_req & ~if_valid_q;
  assign stall_mem   = dm_req & ~dm_valid_q;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_ctr #(.W(32)) u_perf_if (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_fetch),
    .count (perf_if_wait)
  );

  mem_arb_perf_ctr #(.W(32)) u_perf_dm (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_mem),
    .count (perf_dm_wait)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus memory responder; also covers MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_wstrb = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_fetch;
  logic        stall_mem;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_dm_wait;
`endif

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_wstrb    (dm_wstrb),
    .dm_rdata    (dm_rdata),
    .dm_valid    (dm_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .stall_fetch (stall_fetch),
    .stall_mem   (stall_mem)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_dm_wait (perf_dm_wait)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word-addressed memory image; unwritten words return an address-derived pattern.
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] wd;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Memory responder: answers rdy_delay cycles after mem_req first appears; spur pulses ready while idle.
  int unsigned rdy_delay = 0;
  bit          spur = 1'b0;
  int unsigned wcnt = 0;
  bit          rdone = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      wcnt      = 0;
      rdone     = 1'b0;
    end else begin
      #1;
      mem_ready = 1'b0;
      if (mem_req && !rdone) begin
        if (wcnt >= rdy_delay) begin
          mem_ready = 1'b1;
          rdone     = 1'b1;
          mem_rdata = mem_rd(mem_addr);
          if (mem_we) begin
            wd = mem_rd(mem_addr);
            for (int b = 0; b < 4; b++) begin
              if (mem_wstrb[b]) wd[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            mem_img[mem_addr] = wd;
          end
        end else begin
          wcnt++;
        end
      end else if (!mem_req) begin
        wcnt  = 0;
        rdone = 1'b0;
        if (spur) begin
          mem_ready = 1'b1;
          mem_rdata = 32'hBAD0_BAD0;
        end
      end
    end
  end

  // Transaction-level reference: who owns the memory, what was latched, what completes.
  int unsigned m_owner = 0;
  int unsigned m_cnt = 0;
  logic        exp_req = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  logic        exp_if_valid = 1'b0;
  logic        exp_dm_valid = 1'b0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_cnt = 0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0;
      exp_wdata = '0; exp_wstrb = '0; exp_if_valid = 1'b0; exp_dm_valid = 1'b0;
      exp_if_rdata = '0; exp_dm_rdata = '0;
    end else begin
      exp_if_valid = 1'b0;
      exp_dm_valid = 1'b0;
      if (m_owner == 0) begin
        if (dm_req && !(if_req && (m_cnt == STARVE_MAX))) begin
          m_owner = 2; exp_req = 1'b1; exp_we = dm_we; exp_addr = dm_addr;
          exp_wdata = dm_wdata; exp_wstrb = dm_we ? dm_wstrb : 4'h0;
          m_cnt = if_req ? ((m_cnt < STARVE_MAX) ? m_cnt + 1 : m_cnt) : 0;
        end else if (if_req) begin
          m_owner = 1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = if_addr; exp_wstrb = 4'h0;
          m_cnt = 0;
        end else begin
          m_cnt = 0;
        end
      end else if (mem_ready) begin
        if (m_owner == 1) begin
          exp_if_valid = 1'b1;
          exp_if_rdata = mem_rdata;
        end else begin
          exp_dm_valid = 1'b1;
          if (!exp_we) exp_dm_rdata = mem_rdata;
        end
        m_owner = 0;
        exp_req = 1'b0;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  int unsigned n_if_stall = 0;
  int unsigned n_dm_stall = 0;
`endif

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    chk("mem_req", 64'(mem_req), 64'(exp_req));
    if (exp_req) begin
      chk("mem_we", 64'(mem_we), 64'(exp_we));
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
      chk("mem_wstrb", 64'(mem_wstrb), 64'(exp_wstrb));
      if (exp_we) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    end
    chk("if_valid", 64'(if_valid), 64'(exp_if_valid));
    chk("dm_valid", 64'(dm_valid), 64'(exp_dm_valid));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    chk("dm_rdata", 64'(dm_rdata), 64'(exp_dm_rdata));
    chk("stall_fetch", 64'(stall_fetch), 64'(if_req & ~exp_if_valid));
    chk("stall_mem", 64'(stall_mem), 64'(dm_req & ~exp_dm_valid));
`ifdef MEM_ARB_PERF_EN
    if (!rst_n) begin
      n_if_stall = 0;
      n_dm_stall = 0;
    end
    chk("perf_if_wait", 64'(perf_if_wait), 64'(n_if_stall));
    chk("perf_dm_wait", 64'(perf_dm_wait), 64'(n_dm_stall));
    if (rst_n && if_req && !exp_if_valid) n_if_stall++;
    if (rst_n && dm_req && !exp_dm_valid) n_dm_stall++;
`endif
  end

  task automatic wait_valid(input bit is_dm, input int maxc, output int n);
    n = 0;
    while (!(is_dm ? dm_valid : if_valid) && (n < maxc)) begin
      step();
      n++;
    end
    chk(is_dm ? "dm_valid wait" : "if_valid wait", 64'(is_dm ? dm_valid : if_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no completion by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          sf;
    int          ifs;
    logic        prev;
    logic [31:0] q[$];
    logic [31:0] exp_ord [11];
`ifdef MEM_ARB_PERF_EN
    logic [31:0] p0;
`endif
    mem_img[32'h0]   = 32'h0000_0013;
    mem_img[32'h100] = 32'h1111_0100;
    mem_img[32'h200] = 32'h2222_0200;
    mem_img[32'h300] = 32'h3333_0300;
    mem_img[32'h400] = 32'h4444_0400;

    // Reset values.
    #3;
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst if_valid", 64'(if_valid), 64'd0);
    chk("rst dm_valid", 64'(dm_valid), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst if_rdata", 64'(if_rdata), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Single fetch, zero-wait memory.
    rdy_delay = 0;
    if_addr = 32'h0; if_req = 1'b1;
    step();
    chk("t1 mem_req", 64'(mem_req), 64'd1);
    chk("t1 mem_addr", 64'(mem_addr), 64'h0);
    chk("t1 mem_wstrb", 64'(mem_wstrb), 64'h0);
    wait_valid(1'b0, 10, n);
    chk("t1 latency", 64'(n), 64'd1);
    chk("t1 if_rdata", 64'(if_rdata), 64'h0000_0013);
    if_req = 1'b0;
    step();
    chk("t1 no regrant", 64'(mem_req), 64'd0);

    // Simultaneous requests: data first, fetch after.
`ifdef MEM_ARB_PERF_EN
    p0 = perf_if_wait;
`endif
    if_addr = 32'h200; dm_addr = 32'h100; dm_we = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    #1;
    sf = 0; prev = 1'b0; q.delete();
    for (int c = 0; c < 20; c++) begin
      if (stall_fetch) sf++;
      if (mem_req && !prev) q.push_back(mem_addr);
      prev = mem_req;
      if (dm_valid) begin
        chk("t2 dm_rdata", 64'(dm_rdata), 64'h1111_0100);
        dm_req = 1'b0;
      end
      if (if_valid) break;
      step();
    end
    chk("t2 if_valid", 64'(if_valid), 64'd1);
    chk("t2 if_rdata", 64'(if_rdata), 64'h2222_0200);
    chk("t2 stall_fetch cycles", 64'(sf), 64'd4);
    chk("t2 grant count", 64'(q.size()), 64'd2);
    if (q.size() >= 2) begin
      chk("t2 first grant", 64'(q[0]), 64'h100);
      chk("t2 second grant", 64'(q[1]), 64'h200);
    end
`ifdef MEM_ARB_PERF_EN
    chk("t2 perf_if_wait delta", 64'(perf_if_wait - p0), 64'(sf));
`endif
    if_req = 1'b0;
    step();

    // Starvation guard: both held; fetch re-raised once after its first service.
    exp_ord = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300,
                32'h400, 32'h400, 32'h400, 32'h400, 32'h400, 32'h300};
    if_addr = 32'h300; dm_addr = 32'h400; dm_we = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    prev = 1'b0; ifs = 0; q.delete();
    for (int c = 0; (c < 80) && (ifs < 2); c++) begin
      if (mem_req && !prev) q.push_back(mem_addr);
      prev = mem_req;
      if (if_valid) begin
        if_req = 1'b0;
        ifs++;
      end else if (!if_req && (ifs == 1)) begin
        if_req = 1'b1;
      end
      if (ifs < 2) step();
    end
    dm_req = 1'b0;
    chk("t3 fetches served", 64'(ifs), 64'd2);
    chk("t3 grant count", 64'(q.size()), 64'd11);
    for (int i = 0; (i < 11) && (i < q.size()); i++) begin
      chk($sformatf("t3 grant %0d", i), 64'(q[i]), 64'(exp_ord[i]));
    end
    step();
    step();

    // Slow store: command must stay put, load data untouched.
    rdy_delay = 5;
    dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF; dm_req = 1'b1;
    wait_valid(1'b1, 20, n);
    chk("t4 latency", 64'(n), 64'd7);
    chk("t4 dm_rdata kept", 64'(dm_rdata), 64'h4444_0400);
    chk("t4 mem written", 64'(mem_rd(32'h40)), 64'hDEAD_BEEF);
    dm_req = 1'b0;
    step();
    rdy_delay = 0;
    dm_wdata = 32'h1234_5678; dm_wstrb = 4'b0011; dm_req = 1'b1;
    wait_valid(1'b1, 10, n);
    dm_req = 1'b0;
    step();
    dm_we = 1'b0; dm_wstrb = 4'h0; dm_req = 1'b1;
    wait_valid(1'b1, 10, n);
    chk("t4 partial store", 64'(dm_rdata), 64'hDEAD_5678);
    dm_req = 1'b0;
    step();

    // Stray mem_ready while idle, then a fetch whose request drops mid-flight.
    spur = 1'b1;
    step();
    step();
    chk("spur mem_req", 64'(mem_req), 64'd0);
    chk("spur if_valid", 64'(if_valid), 64'd0);
    chk("spur dm_valid", 64'(dm_valid), 64'd0);
    spur = 1'b0;
    if_addr = 32'h0; if_req = 1'b1;
    step();
    if_req = 1'b0;
    wait_valid(1'b0, 10, n);
    chk("drop latency", 64'(n), 64'd1);
    chk("drop if_rdata", 64'(if_rdata), 64'h0000_0013);
    step();

    // Async reset in the middle of a data access.
    rdy_delay = 4;
    dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hCAFE_F00D; dm_wstrb = 4'hF; dm_req = 1'b1;
    step();
    step();
    chk("t5 busy mem_req", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 rst mem_req", 64'(mem_req), 64'd0);
    chk("t5 rst dm_valid", 64'(dm_valid), 64'd0);
    chk("t5 rst if_valid", 64'(if_valid), 64'd0);
    chk("t5 rst mem_addr", 64'(mem_addr), 64'd0);
    dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = 4'h0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    rdy_delay = 0;
    if_addr = 32'h0; if_req = 1'b1;
    step();
    chk("t5 mem_req after reset", 64'(mem_req), 64'd1);
    wait_valid(1'b0, 10, n);
    chk("t5 latency", 64'(n), 64'd1);
    chk("t5 if_rdata", 64'(if_rdata), 64'h0000_0013);
    chk("t5 store abandoned", 64'(mem_img.exists(32'h80)), 64'd0);
    if_req = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
